// File: rtl/multicycle_control_pkg.sv
// mc_pkg: shared types and encodings for the multi-cycle MIPS main control.
//   state_t        control FSM states
//   OP_*           opcode field values (IR[31:26]) recognised by DECODE
//   alu_op_t       encoding consumed by the ALU control decoder
//   alu_src_b_t    ALU B-operand mux select
//   pc_source_t    next-PC mux select
//   fault_code_t   trap cause reported on fault_code
//   ctrl_t         bundle of every per-state strobe produced by mc_output_decode
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        RTYPE_WB,
        EXEC_ADDI,
        EXEC_SLTI,
        EXEC_LOGI,
        IMM_WB,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        BRANCH,
        JUMP,
        FAULT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SLT   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_LOGI  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_source_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_ILLEGAL = 2'b01,
        FC_TIMEOUT = 2'b10
    } fault_code_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        pc_source_t pc_source;
        logic       fault;
    } ctrl_t;

    // States that hold the memory port and therefore run the wait counter.
    function automatic logic is_wait_state(state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control <-> datapath bundle for the multi-cycle core.
//   opcode, zero, mem_ready          datapath/memory status into the controller
//   pc_write .. pc_source            datapath strobes and mux selects
//   fault, fault_code                trap status
//   retired [CNT_W]                  completed-instruction count
// Modports: master = controller side, slave = datapath side.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, fault, fault_code, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, fault, fault_code, retired
    );

endinterface

// File: rtl/multicycle_control_output_decode.sv
// mc_output_decode: combinational state-to-strobe table for the main control.
//   state      current FSM state
//   mem_ready  memory handshake; qualifies ir_write/pc_write in FETCH
//   en         low forces every strobe to 0 (held low while in reset)
//   ctrl       decoded strobes and mux selects
module mc_output_decode
    import mc_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   en,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        if (en) begin
            case (state)
                FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    // IR and PC+4 commit only on the cycle the fetch completes.
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                DECODE: begin
                    // Precompute the branch target into ALUOut.
                    ctrl.alu_src_b = SRCB_IMM_SH2;
                    ctrl.alu_op    = ALU_ADD;
                end
                EXEC_R: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                RTYPE_WB: begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                end
                EXEC_ADDI, MEMADR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                EXEC_SLTI: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_SLT;
                end
                EXEC_LOGI: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_LOGI;
                end
                IMM_WB: begin
                    ctrl.reg_write = 1'b1;
                end
                MEMRD: begin
                    ctrl.iord     = 1'b1;
                    ctrl.mem_read = 1'b1;
                end
                MEMWB: begin
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                end
                MEMWR: begin
                    ctrl.iord      = 1'b1;
                    ctrl.mem_write = 1'b1;
                end
                BRANCH: begin
                    // beq compares by subtraction; the datapath forces the
                    // funct path to sub while this state is active.
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_REG;
                    ctrl.alu_op        = ALU_FUNCT;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
                JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
                FAULT: begin
                    ctrl.fault = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multi-cycle MIPS core.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    controller side of multicycle_control_if (status in, strobes,
//          fault status and retired-instruction count out)
// Parameters:
//   TIMEOUT  cycles allowed waiting on mem_ready in one memory state (2..255)
//   CNT_W    width of the retired-instruction counter
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | read instruction at PC, PC <= PC+4 when memory completes
// DECODE    | decode opcode, branch target into ALUOut
// EXEC_R    | R-type ALU operation
// RTYPE_WB  | write rd, retire
// EXEC_ADDI | A + imm
// EXEC_SLTI | A < imm
// EXEC_LOGI | andi / ori / xori
// IMM_WB    | write rt, retire
// MEMADR    | effective address A + imm
// MEMRD     | load access, wait for mem_ready
// MEMWB     | write loaded data to rt, retire
// MEMWR     | store access, retire on mem_ready
// BRANCH    | beq: conditional PC load from ALUOut, retire
// JUMP      | PC <= jump target, retire
// FAULT     | trap; absorbing until reset
module multicycle_control
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master bus
);

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] retired_q;
    fault_code_t      fault_code_q;
    fault_code_t      fault_code_next;
    logic             retire;
    logic             timed_out;
    ctrl_t            ctrl;

    // zero only qualifies pc_write_cond inside the datapath.
    logic unused_zero;
    assign unused_zero = bus.zero;

    assign timed_out = (wait_cnt == WAIT_LIMIT) && !bus.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            fault_code_q <= FC_NONE;
        end else begin
            state        <= state_next;
            fault_code_q <= fault_code_next;
        end
    end

    always_comb begin
        state_next      = state;
        fault_code_next = fault_code_q;
        retire          = 1'b0;
        case (state)
            FETCH: begin
                if (bus.mem_ready) begin
                    state_next = DECODE;
                end else if (timed_out) begin
                    state_next      = FAULT;
                    fault_code_next = FC_TIMEOUT;
                end
            end
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                  state_next = EXEC_R;
                    OP_LW, OP_SW:              state_next = MEMADR;
                    OP_ADDI:                   state_next = EXEC_ADDI;
                    OP_SLTI:                   state_next = EXEC_SLTI;
                    OP_ANDI, OP_ORI, OP_XORI:  state_next = EXEC_LOGI;
                    OP_BEQ:                    state_next = BRANCH;
                    OP_J:                      state_next = JUMP;
                    default: begin
                        state_next      = FAULT;
                        fault_code_next = FC_ILLEGAL;
                    end
                endcase
            end
            EXEC_R:                          state_next = RTYPE_WB;
            EXEC_ADDI, EXEC_SLTI, EXEC_LOGI: state_next = IMM_WB;
            MEMADR: state_next = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                if (bus.mem_ready) begin
                    state_next = MEMWB;
                end else if (timed_out) begin
                    state_next      = FAULT;
                    fault_code_next = FC_TIMEOUT;
                end
            end
            MEMWR: begin
                if (bus.mem_ready) begin
                    state_next = FETCH;
                    retire     = 1'b1;
                end else if (timed_out) begin
                    state_next      = FAULT;
                    fault_code_next = FC_TIMEOUT;
                end
            end
            RTYPE_WB, IMM_WB, MEMWB, BRANCH, JUMP: begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            FAULT:   state_next = FAULT;
            default: state_next = FETCH;
        endcase
    end

    // Any state change clears the counter, which covers entry into each
    // memory state; it only advances while a memory state is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (is_wait_state(state) && !bus.mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Strobes are gated with rst_n so they read 0 throughout reset and
    // show FETCH as soon as reset releases.
    mc_output_decode u_output_decode (
        .state     (state),
        .mem_ready (bus.mem_ready),
        .en        (rst_n),
        .ctrl      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.iord          = ctrl.iord;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.fault         = ctrl.fault;
    assign bus.fault_code    = fault_code_q;
    assign bus.retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (TIMEOUT=4).
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       fault;
        logic [1:0] fault_code;
    } outs_t;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        outs_t       o;
        logic [31:0] ret;
    } vec_t;

    typedef struct {
        string       name;
        outs_t       o;
        logic [31:0] ret;
    } exp_t;

    localparam outs_t E_ZERO     = '0;
    localparam outs_t E_FETCH_W  = '{mem_read:1'b1, alu_src_b:2'b01, default:0};
    localparam outs_t E_FETCH_R  = '{mem_read:1'b1, ir_write:1'b1, pc_write:1'b1, alu_src_b:2'b01, default:0};
    localparam outs_t E_DECODE   = '{alu_src_b:2'b11, default:0};
    localparam outs_t E_EXEC_R   = '{alu_src_a:1'b1, alu_op:2'b10, default:0};
    localparam outs_t E_RWB      = '{reg_dst:1'b1, reg_write:1'b1, default:0};
    localparam outs_t E_ADDI     = '{alu_src_a:1'b1, alu_src_b:2'b10, default:0};
    localparam outs_t E_SLTI     = '{alu_src_a:1'b1, alu_src_b:2'b10, alu_op:2'b01, default:0};
    localparam outs_t E_LOGI     = '{alu_src_a:1'b1, alu_src_b:2'b10, alu_op:2'b11, default:0};
    localparam outs_t E_IWB      = '{reg_write:1'b1, default:0};
    localparam outs_t E_MEMADR   = '{alu_src_a:1'b1, alu_src_b:2'b10, default:0};
    localparam outs_t E_MEMRD    = '{iord:1'b1, mem_read:1'b1, default:0};
    localparam outs_t E_MEMWB    = '{mem_to_reg:1'b1, reg_write:1'b1, default:0};
    localparam outs_t E_MEMWR    = '{iord:1'b1, mem_write:1'b1, default:0};
    localparam outs_t E_BRANCH   = '{alu_src_a:1'b1, alu_op:2'b10, pc_write_cond:1'b1, pc_source:2'b01, default:0};
    localparam outs_t E_JUMP     = '{pc_write:1'b1, pc_source:2'b10, default:0};
    localparam outs_t E_FAULT_IL = '{fault:1'b1, fault_code:2'b01, default:0};
    localparam outs_t E_FAULT_TO = '{fault:1'b1, fault_code:2'b10, default:0};

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];
    vec_t vecs[$];

    multicycle_control_if #(.CNT_W(32)) bus ();

    multicycle_control #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t sample();
        outs_t a;
        a.pc_write      = bus.pc_write;
        a.pc_write_cond = bus.pc_write_cond;
        a.iord          = bus.iord;
        a.mem_read      = bus.mem_read;
        a.mem_write     = bus.mem_write;
        a.ir_write      = bus.ir_write;
        a.reg_dst       = bus.reg_dst;
        a.mem_to_reg    = bus.mem_to_reg;
        a.reg_write     = bus.reg_write;
        a.alu_src_a     = bus.alu_src_a;
        a.alu_src_b     = bus.alu_src_b;
        a.alu_op        = bus.alu_op;
        a.pc_source     = bus.pc_source;
        a.fault         = bus.fault;
        a.fault_code    = bus.fault_code;
        return a;
    endfunction

    function automatic void add(input logic [5:0] op, input logic rdy, input outs_t o, input logic [31:0] ret);
        vec_t v;
        v.op  = op;
        v.rdy = rdy;
        v.o   = o;
        v.ret = ret;
        vecs.push_back(v);
    endfunction

    task automatic expect_push(input string name, input outs_t o, input logic [31:0] ret);
        exp_t e;
        e.name = name;
        e.o    = o;
        e.ret  = ret;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t  e;
        outs_t a;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 required>=1");
            return;
        end
        e = sb.pop_front();
        a = sample();
        checks++;
        if (a !== e.o) begin
            errors++;
            $display("FAIL %s outs actual=%05h required=%05h", e.name, a, e.o);
        end
        checks++;
        if (bus.retired !== e.ret) begin
            errors++;
            $display("FAIL %s retired actual=%0d required=%0d", e.name, bus.retired, e.ret);
        end
    endtask

    // Drive one cycle of inputs, check at the falling edge, advance past the rising edge.
    task automatic step(input string name, input logic [5:0] op, input logic rdy,
                        input outs_t o, input logic [31:0] ret);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        expect_push(name, o, ret);
        @(negedge clk);
        check_pop();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b1;
        #1;
        expect_push("in_reset", E_ZERO, 32'd0);
        check_pop();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.zero = 1'b0;

        // add; lw with 3 stall cycles (4th cycle at the limit but ready wins)
        add(6'h00, 1, E_FETCH_R, 0); add(6'h00, 1, E_DECODE, 0);
        add(6'h00, 1, E_EXEC_R, 0);  add(6'h00, 1, E_RWB, 0);
        add(6'h23, 1, E_FETCH_R, 1); add(6'h23, 1, E_DECODE, 1);
        add(6'h23, 1, E_MEMADR, 1);  add(6'h23, 0, E_MEMRD, 1);
        add(6'h23, 0, E_MEMRD, 1);   add(6'h23, 0, E_MEMRD, 1);
        add(6'h23, 1, E_MEMRD, 1);   add(6'h23, 1, E_MEMWB, 1);
        // ori, slti
        add(6'h0D, 1, E_FETCH_R, 2); add(6'h0D, 1, E_DECODE, 2);
        add(6'h0D, 1, E_LOGI, 2);    add(6'h0D, 1, E_IWB, 2);
        add(6'h0A, 1, E_FETCH_R, 3); add(6'h0A, 1, E_DECODE, 3);
        add(6'h0A, 1, E_SLTI, 3);    add(6'h0A, 1, E_IWB, 3);
        // beq, j
        add(6'h04, 1, E_FETCH_R, 4); add(6'h04, 1, E_DECODE, 4);
        add(6'h04, 1, E_BRANCH, 4);
        add(6'h02, 1, E_FETCH_R, 5); add(6'h02, 1, E_DECODE, 5);
        add(6'h02, 1, E_JUMP, 5);
        // addi, sw with one stall, xori
        add(6'h08, 1, E_FETCH_R, 6); add(6'h08, 1, E_DECODE, 6);
        add(6'h08, 1, E_ADDI, 6);    add(6'h08, 1, E_IWB, 6);
        add(6'h2B, 1, E_FETCH_R, 7); add(6'h2B, 1, E_DECODE, 7);
        add(6'h2B, 1, E_MEMADR, 7);  add(6'h2B, 0, E_MEMWR, 7);
        add(6'h2B, 1, E_MEMWR, 7);
        add(6'h0E, 1, E_FETCH_R, 8); add(6'h0E, 1, E_DECODE, 8);
        add(6'h0E, 1, E_LOGI, 8);    add(6'h0E, 1, E_IWB, 8);
        // fetch stalls, then illegal opcode traps
        add(6'h3F, 0, E_FETCH_W, 9); add(6'h3F, 0, E_FETCH_W, 9);
        add(6'h3F, 1, E_FETCH_R, 9); add(6'h3F, 1, E_DECODE, 9);
        add(6'h3F, 1, E_FAULT_IL, 9); add(6'h00, 0, E_FAULT_IL, 9);
        add(6'h23, 1, E_FAULT_IL, 9);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].op, vecs[i].rdy, vecs[i].o, vecs[i].ret);
        end

        // Fetch timeout: four stalled cycles then absorbing FAULT.
        do_reset();
        for (int i = 0; i < 4; i++) step($sformatf("fto_wait%0d", i), 6'h00, 0, E_FETCH_W, 0);
        step("fto_fault0", 6'h00, 1, E_FAULT_TO, 0);
        step("fto_fault1", 6'h00, 0, E_FAULT_TO, 0);
        step("fto_fault2", 6'h00, 1, E_FAULT_TO, 0);

        // Ready on the limit cycle wins.
        do_reset();
        for (int i = 0; i < 3; i++) step($sformatf("flim_wait%0d", i), 6'h00, 0, E_FETCH_W, 0);
        step("flim_ready", 6'h00, 1, E_FETCH_R, 0);
        step("flim_decode", 6'h00, 1, E_DECODE, 0);
        step("flim_exec", 6'h00, 1, E_EXEC_R, 0);

        // Store timeout.
        do_reset();
        step("sto_fetch", 6'h2B, 1, E_FETCH_R, 0);
        step("sto_decode", 6'h2B, 1, E_DECODE, 0);
        step("sto_memadr", 6'h2B, 1, E_MEMADR, 0);
        for (int i = 0; i < 4; i++) step($sformatf("sto_wait%0d", i), 6'h2B, 0, E_MEMWR, 0);
        step("sto_fault", 6'h2B, 1, E_FAULT_TO, 0);

        // Reset asserted mid-store: mem_write drops at once, no retirement.
        do_reset();
        step("rmw_fetch_j", 6'h02, 1, E_FETCH_R, 0);
        step("rmw_decode_j", 6'h02, 1, E_DECODE, 0);
        step("rmw_jump", 6'h02, 1, E_JUMP, 0);
        step("rmw_fetch_sw", 6'h2B, 1, E_FETCH_R, 1);
        step("rmw_decode_sw", 6'h2B, 1, E_DECODE, 1);
        step("rmw_memadr", 6'h2B, 1, E_MEMADR, 1);
        bus.mem_ready = 1'b1;
        expect_push("rmw_memwr", E_MEMWR, 1);
        @(negedge clk);
        check_pop();
        #2;
        rst_n = 1'b0;
        #1;
        expect_push("rmw_async_drop", E_ZERO, 0);
        check_pop();
        @(posedge clk);
        #1;
        expect_push("rmw_held", E_ZERO, 0);
        check_pop();
        rst_n = 1'b1;
        step("rmw_after_fetch", 6'h00, 1, E_FETCH_R, 0);
        step("rmw_after_decode", 6'h00, 1, E_DECODE, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS core.
- Sequences the shared datapath (one ALU, one unified memory port, PC/IR/A/B/ALUOut registers) through fetch, decode, execute, memory and writeback.
- Drives the 2-bit alu_op consumed by the ALU control decoder.
- Handshakes with a variable-latency memory and traps on illegal opcodes and memory timeouts.

Parameters:
- TIMEOUT, 16: maximum cycles spent waiting for mem_ready in one memory state before faulting; legal range 2..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by zero (beq)
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=set-less-than, 10=R-type funct decode, 11=logic-immediate
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- fault  out  1  sticky trap flag
- fault_code  out  2  00=none, 01=illegal opcode, 10=memory timeout
- retired  out  CNT_W  count of completed instructions

Behaviour:
- While rst_n=0: state=FETCH, all outputs 0, wait counter 0, retired 0, fault 0. First edge after release behaves as FETCH.
- Default for any output not listed for a state is 0.
- Outputs are Moore (decoded from state), except ir_write and pc_write in FETCH, and state transitions out of memory states, which are qualified by mem_ready in the same cycle.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - On mem_ready -> DECODE; otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x23 or 0x2B -> MEMADR
  - 0x08 -> EXEC_ADDI
  - 0x0A -> EXEC_SLTI
  - 0x0C, 0x0D, 0x0E -> EXEC_LOGI
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - any other opcode -> FAULT with fault_code=01
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> RTYPE_WB.
- RTYPE_WB: reg_dst=1, reg_write=1, retired++ -> FETCH.
- EXEC_ADDI, EXEC_SLTI, EXEC_LOGI: alu_src_a=1, alu_src_b=10, alu_op=00, 01 and 11 respectively -> IMM_WB.
- IMM_WB: reg_dst=0, reg_write=1, retired++ -> FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD if opcode=0x23, MEMWR if 0x2B.
- MEMRD: iord=1, mem_read=1. On mem_ready -> MEMWB.
- MEMWB: mem_to_reg=1, reg_dst=0, reg_write=1, retired++ -> FETCH.
- MEMWR: iord=1, mem_write=1. On mem_ready: retired++ -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01 treated as compare; pc_write_cond=1, pc_source=01, retired++ -> FETCH.
  - Correction: beq uses subtract, so alu_op=01 is not used here. BRANCH drives alu_op=10 with the funct path forced to sub by the datapath mux. Verification checks alu_op=10 in BRANCH.
- JUMP: pc_write=1, pc_source=10, retired++ -> FETCH.
- Wait counter:
  - Clears on entry to FETCH, MEMRD and MEMWR.
  - Increments each cycle spent in one of those states with mem_ready=0.
  - If it reaches TIMEOUT-1 with mem_ready still 0 -> FAULT, fault_code=10.
  - mem_ready in the same cycle as the limit wins: normal transition, no fault.
- FAULT: absorbing. All strobes 0, fault=1, fault_code held. Exit only via rst_n.
- retired wraps modulo 2^CNT_W. It increments exactly once per completed instruction, on the cycle leaving the final state.
- rst_n asserted mid-access: immediate return to reset values. An in-flight mem_write is dropped, with no partial retirement.

Decomposition:
- Package mc_pkg holds:
  - state enum (FETCH, DECODE, EXEC_R, RTYPE_WB, EXEC_ADDI, EXEC_SLTI, EXEC_LOGI, IMM_WB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP, FAULT)
  - opcode constants
  - alu_op, alu_src_b, pc_source and fault_code encodings
- One sub-module, mc_output_decode: combinational state-to-strobe table plus the FETCH mem_ready qualification.
- The FSM register, wait counter and retired counter stay in the top module.

Test Plan:
- Reset release, mem_ready=1 always, opcode=0x00 -> 4 cycles: FETCH(ir_write=1, pc_write=1), DECODE, EXEC_R(alu_op=10), RTYPE_WB(reg_write=1, reg_dst=1); retired=1.
- lw (0x23) with mem_ready low 3 cycles in MEMRD -> mem_read and iord held 3 extra cycles; MEMWB has mem_to_reg=1; total 8 cycles; retired=1.
- ori (0x0D) then slti (0x0A) -> EXEC state alu_op=11 then 01, alu_src_b=10, reg_dst=0 in IMM_WB; retired=2.
- beq (0x04) -> BRANCH cycle has pc_write_cond=1, pc_source=01, pc_write=0. j (0x02) -> pc_write=1, pc_source=10.
- TIMEOUT=4, mem_ready stuck 0 in FETCH -> FAULT after 4 cycles, fault=1, fault_code=10, all strobes 0 until rst_n. Repeat with mem_ready=1 on the 4th cycle -> DECODE, no fault.
- Opcode 0x3F -> FAULT with fault_code=01. Then assert rst_n=0 mid-MEMWR with mem_write=1 -> mem_write drops asynchronously, retired unchanged.
